// File: rtl/alu_pipe.sv
// alu_pipe: registered, width-generic ALU with valid/ready handshake
// and an internal accumulator; one transaction per cycle, 1-cycle latency.
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  localparam logic [3:0] OP_XOR = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_PAS = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ACA = 4'd6;
  localparam logic [3:0] OP_ACC = 4'd7;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   asum;
  logic [31:0]      sh;
  logic             sh_big;
  logic [WIDTH-1:0] res_n;
  logic             carry_n;
  logic [WIDTH-1:0] acc_n;

  // One-entry output register: free when empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign asum = {1'b0, acc} + {1'b0, a};

  // Out-of-range shift amounts only occur for non-power-of-two widths.
  assign sh     = {{(32-SHW){1'b0}}, b[SHW-1:0]};
  assign sh_big = (sh >= 32'(WIDTH));

  // Next result, carry and accumulator for the offered transaction.
  always_comb begin
    res_n   = '0;
    carry_n = 1'b0;
    acc_n   = acc;
    case (op)
      OP_XOR: res_n = a ^ b;
      OP_ADD: begin
        res_n   = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
      end
      OP_SUB: begin
        res_n   = diff[WIDTH-1:0];
        carry_n = diff[WIDTH];
      end
      OP_PAS: res_n = a;
      OP_SHR: res_n = sh_big ? '0 : (a >> sh);
      OP_SHL: res_n = sh_big ? '0 : (a << sh);
      OP_ACA: begin
        acc_n   = asum[WIDTH-1:0];
        res_n   = asum[WIDTH-1:0];
        carry_n = asum[WIDTH];
      end
      OP_ACC: acc_n = '0;
      default: begin
        res_n   = '0;
        carry_n = 1'b0;
      end
    endcase
  end

  // Output register and accumulator; drain clears valid, data holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      acc       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= res_n;
      carry     <= carry_n;
      zero      <= (res_n == '0);
      acc       <= acc_n;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe
// at WIDTH=4 and WIDTH=8.
module tb_alu_pipe;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, iv4, ir4, ov4, or4, c4, z4;
  logic [3:0] op4, a4, b4, res4, acc4;

  logic       rst8, iv8, ir8, ov8, or8, c8, z8;
  logic [3:0] op8;
  logic [7:0] a8, b8, res8, acc8;

  int tests = 0;
  int fails = 0;

  alu_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4),
    .in_valid(iv4), .in_ready(ir4),
    .op(op4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4),
    .result(res4), .carry(c4),
    .zero(z4), .acc(acc4)
  );

  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8),
    .in_valid(iv8), .in_ready(ir8),
    .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8),
    .result(res8), .carry(c8),
    .zero(z8), .acc(acc8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [3:0] o,
                       input logic [3:0] x,
                       input logic [3:0] y);
    iv4 = 1'b1; op4 = o; a4 = x; b4 = y;
    tick();
    iv4 = 1'b0;
  endtask

  task automatic send8(input logic [3:0] o,
                       input logic [7:0] x,
                       input logic [7:0] y);
    iv8 = 1'b1; op8 = o; a8 = x; b8 = y;
    tick();
    iv8 = 1'b0;
  endtask

  initial begin
    rst4 = 1'b1; iv4 = 1'b0; or4 = 1'b1;
    op4 = '0; a4 = '0; b4 = '0;
    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b1;
    op8 = '0; a8 = '0; b8 = '0;
    tick(); tick();
    rst4 = 1'b0; rst8 = 1'b0;
    #1;
    chk("rst_ir", 32'(ir4), 1);
    chk("rst_ov", 32'(ov4), 0);
    chk("rst_res", 32'(res4), 0);
    chk("rst_acc", 32'(acc4), 0);
    chk("rst_cz", {30'd0, c4, z4}, 0);

    send4(4'd1, 4'h9, 4'h8);
    chk("add_res", 32'(res4), 1);
    chk("add_c", 32'(c4), 1);
    chk("add_z", 32'(z4), 0);
    chk("add_ov", 32'(ov4), 1);

    send4(4'd0, 4'hA, 4'h5);
    chk("xor_res", 32'(res4), 4'hF);
    chk("xor_c", 32'(c4), 0);
    send4(4'd2, 4'h3, 4'h5);
    chk("sub_res", 32'(res4), 4'hE);
    chk("sub_c", 32'(c4), 1);
    send4(4'd3, 4'h7, 4'h2);
    chk("pass_res", 32'(res4), 7);
    send4(4'd4, 4'h8, 4'h3);
    chk("shr_res", 32'(res4), 1);
    send4(4'd4, 4'hF, 4'h5);
    chk("shr_bmask", 32'(res4), 7);
    send4(4'd5, 4'h1, 4'h3);
    chk("shl_res", 32'(res4), 8);
    send4(4'd9, 4'h3, 4'h3);
    chk("op9_res", 32'(res4), 0);
    chk("op9_z", 32'(z4), 1);
    chk("op9_ov", 32'(ov4), 1);
    send4(4'd10, 4'hF, 4'hF);
    chk("op10_c", 32'(c4), 0);
    tick();
    chk("drain_ov", 32'(ov4), 0);

    or4 = 1'b0;
    send4(4'd1, 4'h2, 4'h3);
    chk("bp_res0", 32'(res4), 5);
    chk("bp_ir0", 32'(ir4), 0);
    for (int i = 0; i < 5; i++) begin
      iv4 = 1'b1; op4 = 4'(i); a4 = 4'(i + 3); b4 = 4'(i * 7);
      tick();
      chk("bp_res", 32'(res4), 5);
      chk("bp_ov", 32'(ov4), 1);
      chk("bp_ir", 32'(ir4), 0);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    #1;
    chk("bp_ir_up", 32'(ir4), 1);
    tick();
    chk("bp_drained", 32'(ov4), 0);
    chk("bp_hold", 32'(res4), 5);
    send4(4'd1, 4'h1, 4'h1);
    chk("bp_next", 32'(res4), 2);
    chk("bp_next_ov", 32'(ov4), 1);

    for (int i = 0; i < 8; i++) begin
      iv4 = 1'b1; op4 = 4'd1;
      a4 = 4'(i); b4 = 4'(i + 1);
      #1;
      chk("tp_ir", 32'(ir4), 1);
      tick();
      chk("tp_ov", 32'(ov4), 1);
      chk("tp_res", 32'(res4), 2 * i + 1);
    end
    iv4 = 1'b0;
    tick();
    chk("tp_end", 32'(ov4), 0);

    send4(4'd7, 4'h5, 4'h5);
    chk("clr_acc", 32'(acc4), 0);
    chk("clr_z", 32'(z4), 1);
    send4(4'd6, 4'h9, 4'h0);
    chk("aca1_acc", 32'(acc4), 9);
    chk("aca1_res", 32'(res4), 9);
    chk("aca1_c", 32'(c4), 0);
    or4 = 1'b0;
    iv4 = 1'b1; op4 = 4'd6; a4 = 4'h9; b4 = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("aca_stall", 32'(acc4), 9);
    end
    or4 = 1'b1;
    tick();
    iv4 = 1'b0;
    chk("aca2_acc", 32'(acc4), 2);
    chk("aca2_res", 32'(res4), 2);
    chk("aca2_c", 32'(c4), 1);
    tick();
    chk("aca_once", 32'(acc4), 2);

    send8(4'd5, 8'h01, 8'h07);
    chk("w8_shl", 32'(res8), 8'h80);
    send8(4'd7, 8'h00, 8'h00);
    send8(4'd6, 8'h3C, 8'h00);
    chk("w8_acc", 32'(acc8), 8'h3C);
    chk("w8_ov", 32'(ov8), 1);
    #2;
    rst8 = 1'b1;
    #1;
    chk("mrst_ov", 32'(ov8), 0);
    chk("mrst_acc", 32'(acc8), 0);
    chk("mrst_res", 32'(res8), 0);
    tick();
    rst8 = 1'b0;
    #1;
    chk("mrst_ir", 32'(ir8), 1);
    send8(4'd1, 8'hFF, 8'h01);
    chk("w8_add_res", 32'(res8), 0);
    chk("w8_add_c", 32'(c8), 1);
    chk("w8_add_z", 32'(z8), 1);
    chk("w8_add_ov", 32'(ov8), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
